// File: rtl/vfp_config_sequencer_if.sv
// AXI4-Lite write-only channel bundle used by the config sequencer.
interface vfp_config_sequencer_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  WVALID;
  logic                  WREADY;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WVALID, BREADY,
    input  AWREADY, WREADY, BRESP, BVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WVALID, BREADY,
    output AWREADY, WREADY, BRESP, BVALID
  );
endinterface

// File: rtl/vfp_config_sequencer.sv
// Walks a register table and issues one AXI4-Lite write per entry,
// optionally aligned to the vertical blanking after a camera frame.
// TIMEOUT must be >= 1; RESP waits at most TIMEOUT cycles for BVALID.
module vfp_config_sequencer #(
  parameter  int ADDR_WIDTH  = 8,
  parameter  int DATA_WIDTH  = 32,
  parameter  int NUM_ENTRIES = 16,
  parameter  int TIMEOUT     = 255,
  localparam int IW          = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  start,
  input  logic                  sync_to_frame,
  input  logic                  fvalid,
  output logic [IW-1:0]         tbl_index,
  input  logic [ADDR_WIDTH-1:0] tbl_addr,
  input  logic [DATA_WIDTH-1:0] tbl_data,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            err_code,
  output logic [IW-1:0]         err_index,
  vfp_config_sequencer_if.master axi
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_BLANK, WAIT_FRAME_END, WRITE, RESP, NEXT, FINISH
  } state_t;

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic          last_ent;

  logic aw_hs, w_hs, aw_fin, w_fin;
  logic b_ok, b_err, resp_to, at_last, load;

  assign aw_hs   = axi.AWVALID & axi.AWREADY;
  assign w_hs    = axi.WVALID & axi.WREADY;
  // a channel is finished once its VALID has dropped or handshakes this cycle
  assign aw_fin  = !axi.AWVALID | aw_hs;
  assign w_fin   = !axi.WVALID | w_hs;
  assign b_ok    = axi.BVALID && (axi.BRESP == 2'd0);
  assign b_err   = axi.BVALID && (axi.BRESP != 2'd0);
  assign resp_to = !axi.BVALID && (cnt == CW'(TIMEOUT - 1));
  assign at_last = (tbl_index == IW'(NUM_ENTRIES - 1));
  // address/data are captured on the edge that enters WRITE; tbl_index
  // already points at the entry being written during the preceding cycle
  assign load    = (nxt == WRITE) && (state != WRITE);

  assign busy       = (state != IDLE) && (state != FINISH);
  assign done       = (state == FINISH);
  assign axi.BREADY = (state == RESP);

  // state register
  always_ff @(posedge ACLK) begin
    if (!ARESETN) state <= IDLE;
    else          state <= nxt;
  end

  // next-state decode
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:           if (start) nxt = sync_to_frame ? WAIT_BLANK : WRITE;
      WAIT_BLANK:     if (fvalid) nxt = WAIT_FRAME_END;
      WAIT_FRAME_END: if (!fvalid) nxt = WRITE;
      WRITE:          if (aw_fin && w_fin) nxt = RESP;
      RESP: begin
        if (b_ok)                  nxt = NEXT;
        else if (b_err || resp_to) nxt = FINISH;
      end
      NEXT:           nxt = last_ent ? FINISH : WRITE;
      FINISH:         nxt = IDLE;
      default:        nxt = IDLE;
    endcase
  end

  // write channel, index, response counter and error capture
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      axi.AWADDR  <= '0;
      axi.WDATA   <= '0;
      axi.AWVALID <= 1'b0;
      axi.WVALID  <= 1'b0;
      tbl_index   <= '0;
      err_code    <= 2'd0;
      err_index   <= '0;
      cnt         <= '0;
      last_ent    <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        err_code  <= 2'd0;
        err_index <= '0;
        tbl_index <= '0;
      end
      if (load) begin
        axi.AWADDR  <= tbl_addr;
        axi.WDATA   <= tbl_data;
        axi.AWVALID <= 1'b1;
        axi.WVALID  <= 1'b1;
      end else begin
        if (aw_hs) axi.AWVALID <= 1'b0;
        if (w_hs)  axi.WVALID  <= 1'b0;
      end
      cnt <= (state == RESP) ? cnt + CW'(1) : '0;
      if (state == RESP) begin
        if (b_ok) begin
          // advance here so NEXT already presents the following entry
          last_ent <= at_last;
          if (!at_last) tbl_index <= tbl_index + IW'(1);
        end else if (b_err) begin
          err_code  <= 2'd1;
          err_index <= tbl_index;
        end else if (resp_to) begin
          err_code  <= 2'd2;
          err_index <= tbl_index;
        end
      end
      // park the index at 0 so a start on the first IDLE cycle reads entry 0
      if (state == FINISH) tbl_index <= '0;
    end
  end
endmodule

// File: tb/tb_vfp_config_sequencer.sv
// Bench for vfp_config_sequencer: behavioural AXI slave, frame generator
// and a per-cycle scoreboard built from the table and the planned outcome.
module tb_vfp_config_sequencer;
  localparam int AW = 8, DW = 32, NE = 4, TO = 20, IW = 2;
  localparam int FP = 30, FH = 12;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  logic start = 1'b0, sync_to_frame = 1'b0, fvalid = 1'b0;
  logic [IW-1:0] tbl_index, err_index;
  logic [AW-1:0] tbl_addr;
  logic [DW-1:0] tbl_data;
  logic busy, done;
  logic [1:0] err_code;

  vfp_config_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  vfp_config_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_ENTRIES(NE), .TIMEOUT(TO)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .sync_to_frame(sync_to_frame),
    .fvalid(fvalid), .tbl_index(tbl_index), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .busy(busy), .done(done), .err_code(err_code), .err_index(err_index), .axi(axi)
  );

  always #5 ACLK = ~ACLK;

  logic [AW-1:0] t_addr [NE];
  logic [DW-1:0] t_data [NE];
  assign tbl_addr = t_addr[tbl_index];
  assign tbl_data = t_data[tbl_index];

  int vec = 0, errs = 0;
  // slave configuration
  int aw_dly = 0, w_dly = 0, b_dly = 0, er_at = -1, to_at = -1;
  bit cfg_rand = 0, fv_on = 0;
  int aw_wait = 0, w_wait = 0, b_wait = 0, resp_idx = 0, fc = 0, cyc = 0;
  // model of the running sequence
  bit in_seq = 0, seq_done = 0, exp_sync = 0, seen_high = 0;
  int exp_n = 0, exp_code = 0, exp_idx = 0;
  int n_aw = 0, n_w = 0, n_b = 0, n_done = 0;
  int fall_cyc = -1, first_aw = -1, bready_run = 0, last_run = 0;
  logic [AW-1:0] log_addr [NE];
  logic [DW-1:0] log_data [NE];
  // previous-cycle observations
  bit p_awv = 0, p_wv = 0, p_aw_hs = 0, p_w_hs = 0, p_rstn = 0, p_done = 0, p_fv = 0;
  logic [AW-1:0] p_awaddr;
  logic [DW-1:0] p_wdata;
  logic [IW-1:0] p_idx;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // expected outcome from the fault plan: kind 0 none, 1 bad BRESP, 2 no BVALID
  task automatic plan(input int kind, input int at, input bit sync);
    er_at = (kind == 1) ? at : -1;
    to_at = (kind == 2) ? at : -1;
    exp_n    = (kind == 0) ? NE : at + 1;
    exp_code = kind;
    exp_idx  = (kind == 0) ? 0 : at;
    exp_sync = sync;
    n_aw = 0; n_w = 0; n_b = 0; n_done = 0; resp_idx = 0;
    fall_cyc = -1; first_aw = -1; seen_high = 0; seq_done = 0;
  endtask

  task automatic zero_chk();
    chk("rst_awvalid", axi.AWVALID, 0); chk("rst_wvalid", axi.WVALID, 0);
    chk("rst_bready", axi.BREADY, 0);   chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);           chk("rst_err_code", err_code, 0);
    chk("rst_err_index", err_index, 0); chk("rst_tbl_index", tbl_index, 0);
    chk("rst_awaddr", axi.AWADDR, 0);   chk("rst_wdata", axi.WDATA, 0);
  endtask

  task automatic run_seq(input int kind, input int at, input bit sync, input bit poke);
    plan(kind, at, sync);
    @(negedge ACLK); sync_to_frame = sync; start = 1'b1;
    @(negedge ACLK); start = 1'b0; in_seq = 1'b1;
    for (int i = 0; i < 3000 && !seq_done; i++) begin
      start = poke && (i == 1);
      @(negedge ACLK);
    end
    start = 1'b0;
    if (!seq_done) begin
      vec++; errs++; in_seq = 1'b0;
      $display("FAIL seq_wait: no done within budget, writes %0d of %0d", n_aw, exp_n);
    end
    repeat (6) @(negedge ACLK);
    chk("err_code_hold", err_code, exp_code);
    chk("err_index_hold", err_index, exp_idx);
  endtask

  // stimulus drive (slave, frames) then scoreboard, once per cycle at negedge
  initial begin : drv_mon
    bit aw_hs, w_hs, b_hs;
    axi.AWREADY = 0; axi.WREADY = 0; axi.BVALID = 0; axi.BRESP = 0;
    forever begin
      @(negedge ACLK);
      cyc++; fc++;
      fvalid = fv_on && ((fc % FP) < FH);
      if (!axi.AWVALID) aw_wait = 0;
      if (axi.AWVALID && aw_wait == 0 && cfg_rand) aw_dly = $urandom_range(0, 4);
      axi.AWREADY = (aw_wait >= aw_dly);
      if (axi.AWVALID) aw_wait++;
      if (!axi.WVALID) w_wait = 0;
      if (axi.WVALID && w_wait == 0 && cfg_rand) w_dly = $urandom_range(0, 4);
      axi.WREADY = (w_wait >= w_dly);
      if (axi.WVALID) w_wait++;
      if (!axi.BREADY) b_wait = 0;
      if (axi.BREADY && b_wait == 0 && cfg_rand) b_dly = $urandom_range(0, 3);
      axi.BVALID = (resp_idx != to_at) && (b_wait >= b_dly);
      axi.BRESP  = (resp_idx == er_at) ? 2'd2 : 2'd0;
      if (axi.BREADY) b_wait++;
      #1;
      aw_hs = axi.AWVALID && axi.AWREADY;
      w_hs  = axi.WVALID && axi.WREADY;
      b_hs  = axi.BVALID && axi.BREADY;
      if (ARESETN && p_rstn) begin
        if (p_aw_hs) chk("aw_drop", axi.AWVALID, 0);
        else if (p_awv) begin
          chk("aw_hold", axi.AWVALID, 1); chk("awaddr_stable", axi.AWADDR, p_awaddr);
        end
        if (p_w_hs) chk("w_drop", axi.WVALID, 0);
        else if (p_wv) begin
          chk("w_hold", axi.WVALID, 1); chk("wdata_stable", axi.WDATA, p_wdata);
        end
        if ((axi.AWVALID || axi.WVALID) && (p_awv || p_wv)) chk("index_stable", tbl_index, p_idx);
        chk("bready_legal", axi.BREADY && !(n_aw == n_w && n_aw > n_b), 0);
        if (!done) chk("busy", busy, in_seq);
        if (in_seq && fvalid) seen_high = 1;
        if (in_seq && seen_high && !fvalid && p_fv && fall_cyc < 0) fall_cyc = cyc;
        if (in_seq && axi.AWVALID && first_aw < 0) first_aw = cyc;
        if (axi.BREADY) bready_run++;
        else begin
          if (bready_run > 0) last_run = bready_run;
          bready_run = 0;
        end
        if (aw_hs) begin
          if (n_aw < exp_n) begin
            chk("aw_index", tbl_index, n_aw);
            chk("aw_addr", axi.AWADDR, t_addr[n_aw]);
            log_addr[n_aw] = axi.AWADDR;
          end else chk("extra_aw", n_aw, exp_n - 1);
          n_aw++;
        end
        if (w_hs) begin
          if (n_w < exp_n) begin
            chk("w_data", axi.WDATA, t_data[n_w]);
            log_data[n_w] = axi.WDATA;
          end else chk("extra_w", n_w, exp_n - 1);
          n_w++;
        end
        if (b_hs) begin n_b++; resp_idx++; end
        if (done) begin
          chk("done_expected", in_seq, 1);
          chk("done_single", p_done, 0);
          chk("done_busy", busy, 0);
          chk("err_code", err_code, exp_code);
          chk("err_index", err_index, exp_idx);
          chk("aw_count", n_aw, exp_n);
          chk("w_count", n_w, exp_n);
          if (exp_code == 2) chk("timeout_len", last_run, TO);
          if (exp_sync) chk("frame_first_aw", first_aw - fall_cyc, 1);
          in_seq = 0; seq_done = 1;
        end
      end
      p_awv = axi.AWVALID; p_wv = axi.WVALID; p_aw_hs = aw_hs; p_w_hs = w_hs;
      p_awaddr = axi.AWADDR; p_wdata = axi.WDATA; p_idx = tbl_index;
      p_rstn = ARESETN; p_done = done; p_fv = fvalid;
    end
  end

  initial begin : main
    for (int i = 0; i < NE; i++) begin
      t_addr[i] = AW'(4 * (i + 1)); t_data[i] = DW'(i + 1);
    end
    repeat (3) @(negedge ACLK);
    #2 zero_chk();
    @(negedge ACLK); ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);

    // all-ready write of the literal table
    run_seq(0, -1, 0, 0);
    chk("lit_addr0", log_addr[0], 8'h04); chk("lit_addr3", log_addr[3], 8'h10);
    chk("lit_data1", log_data[1], 32'h2); chk("lit_data3", log_data[3], 32'h4);
    chk("lit_err", err_code, 0);

    // skewed handshakes in both orders, with an ignored start poke
    for (int i = 0; i < NE; i++) begin t_addr[i] = AW'($urandom); t_data[i] = $urandom; end
    aw_dly = 0; w_dly = 3; run_seq(0, -1, 0, 1);
    aw_dly = 3; w_dly = 0; run_seq(0, -1, 0, 0);
    aw_dly = 0; w_dly = 0;

    // frame-aligned start inside and outside the frame
    fv_on = 1;
    while ((fc % FP) != 3) @(negedge ACLK);
    run_seq(0, -1, 1, 0);
    while ((fc % FP) != FH + 3) @(negedge ACLK);
    run_seq(0, -1, 1, 0);
    chk("lit_frame_wait", (fall_cyc - first_aw) < 0 && fall_cyc > 0, 1);

    // slave error on entry 2, then a missing response on entry 0
    run_seq(1, 2, 0, 0);
    chk("lit_bresp_code", err_code, 1); chk("lit_bresp_idx", err_index, 2);
    chk("lit_bresp_writes", n_aw, 3);
    run_seq(2, 0, 0, 0);
    chk("lit_to_code", err_code, 2); chk("lit_to_len", last_run, 20);

    // reset while a write is stalled, then a clean restart from entry 0
    aw_dly = 50; plan(0, -1, 0);
    @(negedge ACLK); start = 1'b1;
    @(negedge ACLK); start = 1'b0; in_seq = 1'b1;
    for (int i = 0; i < 20 && !axi.AWVALID; i++) @(negedge ACLK);
    chk("rst_precond", axi.AWVALID, 1);
    ARESETN = 1'b0; in_seq = 1'b0;
    @(negedge ACLK); #2 zero_chk();
    ARESETN = 1'b1; aw_dly = 0;
    run_seq(0, -1, 0, 0);
    chk("restart_addr0", log_addr[0], t_addr[0]);

    // randomized sequences
    cfg_rand = 1;
    for (int s = 0; s < 14; s++) begin
      int r, kind;
      for (int i = 0; i < NE; i++) begin t_addr[i] = AW'($urandom); t_data[i] = $urandom; end
      r = $urandom_range(0, 9);
      kind = (r < 6) ? 0 : (r < 8) ? 1 : 2;
      repeat ($urandom_range(0, FP)) @(negedge ACLK);
      run_seq(kind, $urandom_range(0, NE - 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/vfp_config_sequencer.md
VFP_CONFIG_SEQUENCER -- requirements
Module: vfp_config_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: width of the AXI4-Lite write address and of each table address entry.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: width of the write data and of each table data entry.
REQ-003 SHALL have parameter NUM_ENTRIES, default 16: number of table entries written per sequence, range 1..256, IW = max(1, clog2(NUM_ENTRIES)).
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum cycles to wait for BVALID after both AW and W have been accepted.
REQ-005 SHALL have port ACLK  in  1  clock; the block has one clock.
REQ-006 SHALL have port ARESETN  in  1  reset, synchronous to ACLK, active-low.
REQ-007 SHALL have port start  in  1  single-cycle request to run the table sequence.
REQ-008 SHALL have port sync_to_frame  in  1  when high at start, writes wait for vertical blanking.
REQ-009 SHALL have port fvalid  in  1  camera frame-valid, already synchronous to ACLK.
REQ-010 SHALL have port tbl_index  out  IW  current table entry index.
REQ-011 SHALL have port tbl_addr  in  ADDR_WIDTH  register address for tbl_index, valid in the same cycle (combinational lookup).
REQ-012 SHALL have port tbl_data  in  DATA_WIDTH  register data for tbl_index, valid in the same cycle.
REQ-013 SHALL have port busy  out  1  high from the cycle after accepted start until done.
REQ-014 SHALL have port done  out  1  one-cycle pulse at sequence end, whether successful or aborted.
REQ-015 SHALL have port err_code  out  2  0 = ok, 1 = BRESP not OKAY, 2 = timeout, 3 = unused.
REQ-016 SHALL have port err_index  out  IW  table index of the failing entry.
REQ-017 SHALL have port AWADDR  out  ADDR_WIDTH  write address.
REQ-018 SHALL have port AWVALID  out  1  write address valid.
REQ-019 SHALL have port AWREADY  in  1  write address ready.
REQ-020 SHALL have port WDATA  out  DATA_WIDTH  write data.
REQ-021 SHALL have port WVALID  out  1  write data valid.
REQ-022 SHALL have port WREADY  in  1  write data ready.
REQ-023 SHALL have port BRESP  in  2  write response.
REQ-024 SHALL have port BVALID  in  1  write response valid.
REQ-025 SHALL have port BREADY  out  1  write response ready.

Function
REQ-026 SHALL implement states IDLE, WAIT_BLANK, WAIT_FRAME_END, WRITE, RESP, NEXT, FINISH.
REQ-027 SHALL, in IDLE, accept start, clear err_code/err_index and set tbl_index = 0; it SHALL go to WAIT_BLANK if sync_to_frame = 1, otherwise to WRITE.
REQ-028 SHALL, in WAIT_BLANK, go to WAIT_FRAME_END when fvalid = 1; in WAIT_FRAME_END it SHALL go to WRITE on the first cycle with fvalid = 0, so the first write follows the fvalid falling edge.
REQ-029 SHALL, on entry to WRITE, register AWADDR = tbl_addr and WDATA = tbl_data and assert AWVALID and WVALID in the same cycle.
REQ-030 SHALL deassert AWVALID and WVALID independently, each in the cycle after its own handshake; simultaneous or either-order handshakes are both legal.
REQ-031 SHALL hold AWADDR, WDATA and tbl_index stable while any VALID is high.
REQ-032 SHALL go to RESP once both handshakes are complete; in RESP it SHALL hold BREADY = 1 and count cycles from 0.
REQ-033 SHALL, on BVALID with BRESP = 0, go to NEXT; on BVALID with BRESP != 0, set err_code = 1, set err_index = tbl_index and go to FINISH.
REQ-034 SHALL, if the RESP counter reaches TIMEOUT without BVALID, set err_code = 2, set err_index and go to FINISH; there is no timeout in WRITE.
REQ-035 SHALL, in NEXT, go to FINISH if tbl_index = NUM_ENTRIES-1, otherwise increment tbl_index and return to WRITE (one idle cycle between writes).
REQ-036 SHALL, in FINISH, pulse done for one cycle, deassert busy and return to IDLE; err_code and err_index SHALL stay held until the next accepted start.
REQ-037 SHALL ignore start while busy, with no queuing.
REQ-038 SHALL keep BREADY = 0 outside RESP.

Reset
REQ-039 SHALL, while ARESETN = 0 at a rising ACLK edge, force state = IDLE and all outputs (AWVALID, WVALID, BREADY, busy, done, err_code, err_index, tbl_index, AWADDR, WDATA) to 0, including mid-transaction, with no completion of an outstanding write.

Verification
REQ-040 SHALL pass: NUM_ENTRIES = 4, sync_to_frame = 0, AWREADY = WREADY = BVALID = 1 always, table {0x04:0x1, 0x08:0x2, 0x0C:0x3, 0x10:0x4} -> 4 writes in order, done pulse, err_code = 0.
REQ-041 SHALL pass: WREADY delayed 3 cycles after AWREADY, then the reverse order -> AWVALID and WVALID drop independently, exactly one write per entry, data stable.
REQ-042 SHALL pass: sync_to_frame = 1, start while fvalid = 1 -> AWVALID first rises 1 cycle after fvalid falls; start while fvalid = 0 -> waits for a full frame, then its end.
REQ-043 SHALL pass: BRESP = 2 on entry 2 -> err_code = 1, err_index = 2, entry 3 not written, done pulses.
REQ-044 SHALL pass: BVALID never asserted -> err_code = 2 after TIMEOUT cycles in RESP; ARESETN low during WRITE -> all outputs 0 next cycle and a new start restarts at index 0.
